// File: rtl/vmem_fill.sv
// Rectangle-fill engine in front of vmem's single write port: draws one 3-bit pixel per
// cycle from a memory-mapped job description, yielding to CPU stores on every cycle.
`timescale 1ns/1ps
module vmem_fill #(
  parameter int unsigned MAX_X = 239,
  parameter int unsigned MAX_Y = 239
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_waddr_i,
  input  logic [2:0]  cpu_wdata_i,
  output logic        vmem_we_o,
  output logic [15:0] vmem_waddr_o,
  output logic [2:0]  vmem_wdata_o,
  output logic        busy_o
);

  localparam logic [7:0] MaxX = 8'(MAX_X);
  localparam logic [7:0] MaxY = 8'(MAX_Y);

  typedef enum logic [1:0] {IDLE, SETUP, RUN} state_e;

  state_e      state_q, state_d;
  logic [7:0]  x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [7:0]  cx1_q, cx1_d, cy1_q, cy1_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic [2:0]  color_q, color_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic       busy, fill_we;
  logic       ctrl_wr, start_wr, abort_wr;
  logic [7:0] cx1_c, cy1_c;
  logic       empty, last;
  logic       unused_ok;

  assign unused_ok = ^{wdata_i[31:16], addr_i[1:0]};

  assign ctrl_wr  = we_i && (addr_i[3:2] == 2'd3);
  assign abort_wr = ctrl_wr && wdata_i[1];
  assign start_wr = ctrl_wr && wdata_i[0] && !wdata_i[1];

  // Clamped corner; x0/y0 beyond MAX_* also yields empty because cx1/cy1 never exceed MAX_*.
  assign cx1_c = (x1_q > MaxX) ? MaxX : x1_q;
  assign cy1_c = (y1_q > MaxY) ? MaxY : y1_q;
  assign empty = (x0_q > cx1_c) || (y0_q > cy1_c);
  assign last  = (x_q == cx1_q) && (y_q == cy1_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_wr) state_d = SETUP;
      SETUP:   state_d = (abort_wr || empty) ? IDLE : RUN;
      RUN:     if (abort_wr || (fill_we && last)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != IDLE);
    fill_we      = (state_q == RUN) && !cpu_we_i && !rst_i;
    vmem_we_o    = cpu_we_i | fill_we;
    vmem_waddr_o = cpu_we_i ? cpu_waddr_i : {y_q, x_q};
    vmem_wdata_o = cpu_we_i ? cpu_wdata_i : color_q;
    busy_o       = busy;
    rdata_o      = rdata_q;
  end

  always_comb begin
    x0_d      = x0_q;
    y0_d      = y0_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    color_d   = color_q;
    cx1_d     = cx1_q;
    cy1_d     = cy1_q;
    x_d       = x_q;
    y_d       = y_q;
    pix_cnt_d = pix_cnt_q;
    if (!busy && we_i) begin
      unique case (addr_i[3:2])
        2'd0:    {y0_d, x0_d} = wdata_i[15:0];
        2'd1:    {y1_d, x1_d} = wdata_i[15:0];
        2'd2:    color_d      = wdata_i[2:0];
        default: ;
      endcase
    end
    if (state_q == SETUP) begin
      cx1_d     = cx1_c;
      cy1_d     = cy1_c;
      x_d       = x0_q;
      y_d       = y0_q;
      pix_cnt_d = '0;
    end
    if (fill_we) begin
      pix_cnt_d = pix_cnt_q + 16'd1;
      if (x_q == cx1_q) begin
        x_d = x0_q;
        y_d = y_q + 8'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    unique case (addr_i[3:2])
      2'd0:    rdata_d = {16'b0, y0_q, x0_q};
      2'd1:    rdata_d = {16'b0, y1_q, x1_q};
      2'd2:    rdata_d = {16'b0, pix_cnt_q};
      default: rdata_d = {31'b0, busy};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      color_q   <= '0;
      cx1_q     <= '0;
      cy1_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      pix_cnt_q <= '0;
      rdata_q   <= '0;
    end else begin
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      color_q   <= color_d;
      cx1_q     <= cx1_d;
      cy1_q     <= cy1_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pix_cnt_q <= pix_cnt_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_vmem_fill.sv
// Bench for vmem_fill: a raster-order pixel queue model checked against every vmem write.
`timescale 1ns/1ps
module tb_vmem_fill;
  localparam int MAXC = 239;

  logic        clk = 1'b0;
  logic        rst_i, we_i, cpu_we_i;
  logic [3:0]  addr_i;
  logic [31:0] wdata_i, rdata_o;
  logic [15:0] cpu_waddr_i;
  logic [2:0]  cpu_wdata_i;
  logic        vmem_we_o;
  logic [15:0] vmem_waddr_o;
  logic [2:0]  vmem_wdata_o;
  logic        busy_o;

  vmem_fill #(.MAX_X(239), .MAX_Y(239)) dut (
    .clk_i(clk), .rst_i(rst_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .cpu_we_i(cpu_we_i), .cpu_waddr_i(cpu_waddr_i),
    .cpu_wdata_i(cpu_wdata_i), .vmem_we_o(vmem_we_o), .vmem_waddr_o(vmem_waddr_o),
    .vmem_wdata_o(vmem_wdata_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [18:0] exp_q[$];
  int fill_wr, busy_cyc, mon_err, first_wr_cyc;

  always @(negedge clk) begin
    logic [18:0] e;
    if (busy_o) busy_cyc++;
    if (cpu_we_i) begin
      if (!vmem_we_o || vmem_waddr_o != cpu_waddr_i || vmem_wdata_o != cpu_wdata_i) mon_err++;
    end else if (vmem_we_o) begin
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      fill_wr++;
      if (exp_q.size() == 0) mon_err++;
      else begin
        e = exp_q.pop_front();
        if ({vmem_waddr_o, vmem_wdata_o} != e) mon_err++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
    addr_i = a; wdata_i = d; we_i = 1'b1;
    tick();
    we_i = 1'b0;
  endtask

  task automatic reg_rd(input logic [3:0] a, output logic [31:0] d);
    addr_i = a;
    tick();
    d = rdata_o;
  endtask

  // Expected pixels of one job, in raster order, after clamping the far corner.
  function automatic int build_model(input logic [15:0] p0, input logic [15:0] p1,
                                     input logic [2:0] col);
    int x0 = int'(p0[7:0]), y0 = int'(p0[15:8]);
    int x1 = int'(p1[7:0]), y1 = int'(p1[15:8]);
    int cx1 = (x1 > MAXC) ? MAXC : x1;
    int cy1 = (y1 > MAXC) ? MAXC : y1;
    exp_q.delete();
    if (x0 > cx1 || y0 > cy1) return 0;
    for (int y = y0; y <= cy1; y++)
      for (int x = x0; x <= cx1; x++)
        exp_q.push_back({8'(y), 8'(x), col});
    return (cx1 - x0 + 1) * (cy1 - y0 + 1);
  endfunction

  task automatic clear_mon();
    fill_wr = 0; busy_cyc = 0; mon_err = 0; first_wr_cyc = -1;
  endtask

  task automatic run_fill(input string tag, input logic [15:0] p0, input logic [15:0] p1,
                          input logic [2:0] col, input int stall_at, input int stall_pct,
                          input int abort_after, input bit poke_p0);
    int n, stalls, j, limit, start_cyc;
    bit aborted;
    logic [31:0] d;
    reg_wr(4'h0, {16'h0, p0});
    reg_wr(4'h4, {16'h0, p1});
    reg_wr(4'h8, {29'h0, col});
    n = build_model(p0, p1, col);
    clear_mon();
    stalls = 0; aborted = 1'b0; j = 2; limit = 4 * n + 20;
    start_cyc = cyc;
    reg_wr(4'hC, 32'h1);
    tick();
    while (busy_o && j < limit) begin
      cpu_we_i = 1'b0;
      if (abort_after >= 0 && !aborted && fill_wr >= abort_after) begin
        aborted = 1'b1; addr_i = 4'hC; wdata_i = 32'h2; we_i = 1'b1;
      end else if (poke_p0 && j == 4) begin
        addr_i = 4'h0; wdata_i = 32'h3333; we_i = 1'b1;
      end else if (j == stall_at || $urandom_range(99) < stall_pct) begin
        cpu_we_i    = 1'b1;
        cpu_waddr_i = (j == stall_at) ? 16'h1234 : 16'($urandom);
        cpu_wdata_i = (j == stall_at) ? 3'd2 : 3'($urandom);
        stalls++;
      end
      tick();
      we_i = 1'b0;
      j++;
    end
    cpu_we_i = 1'b0;
    chk({tag, "_done"}, {31'b0, busy_o}, 32'd0);
    tick(); tick(); tick();
    chk({tag, "_seq"}, mon_err, 0);
    if (aborted) begin
      chk({tag, "_nwr"}, fill_wr, abort_after + 1);
      reg_rd(4'h8, d);
      chk({tag, "_pix"}, d, abort_after + 1);
    end else begin
      chk({tag, "_nwr"}, fill_wr, n);
      chk({tag, "_left"}, exp_q.size(), 0);
      chk({tag, "_busy"}, busy_cyc, (n > 0) ? n + 1 + stalls : 1);
      if (n > 0 && stall_pct == 0 && stall_at < 0)
        chk({tag, "_lat"}, first_wr_cyc - start_cyc, 2);
      reg_rd(4'h8, d);
      chk({tag, "_pix"}, d, n);
    end
    reg_rd(4'hC, d);
    chk({tag, "_ctrl"}, d, 0);
    if (poke_p0) begin
      reg_rd(4'h0, d);
      chk({tag, "_p0"}, d, {16'h0, p0});
    end
  endtask

  task automatic reset_mid_fill();
    logic [31:0] d;
    int n, k, frozen;
    reg_wr(4'h0, 32'h0000);
    reg_wr(4'h4, 32'h0909);
    reg_wr(4'h8, 32'h3);
    n = build_model(16'h0000, 16'h0909, 3'd3);
    clear_mon();
    reg_wr(4'hC, 32'h1);
    k = 0;
    while (fill_wr < 5 && k < 50) begin tick(); k++; end
    chk("rst_reach", {31'b0, fill_wr >= 5}, 32'd1);
    rst_i = 1'b1;
    #3;
    chk("rst_we", {31'b0, vmem_we_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    frozen = fill_wr;
    reg_rd(4'h0, d); chk("rst_p0", d, 0);
    reg_rd(4'h4, d); chk("rst_p1", d, 0);
    reg_rd(4'h8, d); chk("rst_pix", d, 0);
    chk("rst_nowr", fill_wr, frozen);
    chk("rst_n", {31'b0, n == 100}, 32'd1);
    exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [7:0] rx0, rx1, ry0, ry1;
    rst_i = 1'b1; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    cpu_we_i = 1'b0; cpu_waddr_i = '0; cpu_wdata_i = '0;
    clear_mon();
    tick(); tick();
    rst_i = 1'b0;
    chk("init_rdata", rdata_o, 0);
    chk("init_busy", {31'b0, busy_o}, 0);
    chk("init_we", {31'b0, vmem_we_o}, 0);
    reg_rd(4'h4, d); chk("init_p1", d, 0);

    reg_wr(4'hC, 32'h2);
    reg_rd(4'hC, d); chk("idle_abort", d, 0);
    reg_wr(4'hC, 32'h3);
    chk("idle_start_abort", {31'b0, busy_o}, 0);

    run_fill("t1", 16'h140A, 16'h150C, 3'd5, -1, 0, -1, 1'b0);
    run_fill("t3", 16'h0505, 16'h0504, 3'd4, -1, 0, -1, 1'b0);
    run_fill("t4", 16'h2010, 16'h2013, 3'd6, 3, 0, -1, 1'b0);
    run_fill("t5", 16'h0000, 16'h0909, 3'd1, -1, 0, 10, 1'b1);
    reset_mid_fill();
    run_fill("t6", 16'h0302, 16'h0403, 3'd2, -1, 0, -1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      rx0 = 8'(225 + $urandom_range(30));
      ry0 = 8'(225 + $urandom_range(30));
      rx1 = 8'((int'(rx0) + $urandom_range(14) > 257) ? 255 : int'(rx0) + $urandom_range(14) - 2);
      ry1 = 8'((int'(ry0) + $urandom_range(14) > 257) ? 255 : int'(ry0) + $urandom_range(14) - 2);
      run_fill("rnd", {ry0, rx0}, {ry1, rx1}, 3'($urandom), -1, 25, -1, 1'b0);
    end

    run_fill("t2", 16'h0000, 16'hFFFF, 3'd7, -1, 0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
